// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: one outstanding read to instruction memory, buffers the
// returned word and hands {pc, inst} to decode with a valid/allowin handshake.
// In-flight fetches are discarded on redirect.
module ifetch_unit #(
  parameter logic [31:0] INST_NOP = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              fetch_stall,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [31:0]       inst_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_inst,
  output logic              if_adel,
  input  logic              id_allowin
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e              r_state, w_state_d;
  logic                r_cancel, w_cancel_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d;
  logic [ADDR_W-1:0]   r_if_pc, w_if_pc_d;
  logic [31:0]         r_if_inst, w_if_inst_d;
  logic                r_if_adel, w_if_adel_d;

  // State and payload registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= StIdle;
      r_cancel  <= 1'b0;
      r_addr    <= '0;
      r_if_pc   <= '0;
      r_if_inst <= '0;
      r_if_adel <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cancel  <= w_cancel_d;
      r_addr    <= w_addr_d;
      r_if_pc   <= w_if_pc_d;
      r_if_inst <= w_if_inst_d;
      r_if_adel <= w_if_adel_d;
    end
  end

  // Next-state logic: fetch sequencing, cancel tracking and payload capture.
  always_comb begin
    w_state_d   = r_state;
    w_cancel_d  = r_cancel;
    w_addr_d    = r_addr;
    w_if_pc_d   = r_if_pc;
    w_if_inst_d = r_if_inst;
    w_if_adel_d = r_if_adel;
    unique case (r_state)
      StIdle: begin
        // A flush means pc is about to change, so it is not worth fetching.
        if (!flush) begin
          if (pc[1:0] != 2'b00) begin
            w_if_pc_d   = pc;
            w_if_inst_d = INST_NOP;
            w_if_adel_d = 1'b1;
            w_state_d   = StHold;
          end else begin
            w_addr_d  = pc;
            w_state_d = StReq;
          end
        end
      end
      StReq: begin
        // The request cannot be withdrawn; remember to drop its response.
        if (flush) w_cancel_d = 1'b1;
        if (inst_addr_ok) w_state_d = StWait;
      end
      StWait: begin
        if (inst_data_ok) begin
          if (r_cancel || flush) begin
            w_cancel_d = 1'b0;
            w_state_d  = StIdle;
          end else begin
            w_if_pc_d   = r_addr;
            w_if_inst_d = inst_rdata;
            w_if_adel_d = 1'b0;
            w_state_d   = StHold;
          end
        end else if (flush) begin
          w_cancel_d = 1'b1;
        end
      end
      StHold: begin
        if (flush || id_allowin) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; stall releases only on a real handoff.
  always_comb begin
    inst_req    = (r_state == StReq);
    inst_addr   = r_addr;
    if_valid    = (r_state == StHold);
    if_pc       = r_if_pc;
    if_inst     = r_if_inst;
    if_adel     = r_if_adel;
    fetch_stall = !((r_state == StHold) && id_allowin && !flush);
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: directed scenarios with literal expectations, then
// randomized traffic against a transaction-level model, a PC register and a memory.
module tb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] pc;
  logic        flush;
  logic        fetch_stall;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;
  logic        id_allowin;
  logic [31:0] flush_tgt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ifetch_unit #(.INST_NOP(NOP), .ADDR_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pc           (pc),
    .flush        (flush),
    .fetch_stall  (fetch_stall),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_adel      (if_adel),
    .id_allowin   (id_allowin)
  );

  // Transaction-level model: a fetch is either being offered, in flight (maybe doomed),
  // or delivered as a payload; otherwise the stage is free to start a new one.
  logic        m_offer, m_fly, m_doomed, m_have;
  logic [31:0] m_addr, m_pc, m_inst;
  logic        m_adel;
  logic        m_stall;
  assign m_stall = !(m_have && id_allowin && !flush);

  always @(posedge clk) begin
    if (!resetn) begin
      m_offer <= 1'b0; m_fly <= 1'b0; m_doomed <= 1'b0; m_have <= 1'b0;
      m_addr <= '0; m_pc <= '0; m_inst <= '0; m_adel <= 1'b0;
    end else if (m_have) begin
      if (flush || id_allowin) m_have <= 1'b0;
    end else if (m_offer) begin
      if (flush) m_doomed <= 1'b1;
      if (inst_addr_ok) begin m_offer <= 1'b0; m_fly <= 1'b1; end
    end else if (m_fly) begin
      if (inst_data_ok) begin
        m_fly    <= 1'b0;
        m_doomed <= 1'b0;
        if (!(m_doomed || flush)) begin
          m_have <= 1'b1; m_pc <= m_addr; m_inst <= inst_rdata; m_adel <= 1'b0;
        end
      end else if (flush) begin
        m_doomed <= 1'b1;
      end
    end else if (!flush) begin
      if (pc[1:0] != 2'b00) begin
        m_have <= 1'b1; m_pc <= pc; m_inst <= NOP; m_adel <= 1'b1;
      end else begin
        m_addr <= pc; m_offer <= 1'b1;
      end
    end
  end

  // PC register: redirect beats stall; advances by 4 per handoff.
  always @(posedge clk) begin
    if (!resetn)       pc <= 32'h0;
    else if (flush)    pc <= flush_tgt;
    else if (!m_stall) pc <= pc + 32'd4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Compare DUT against the model on the current cycle.
  task automatic model_cmp();
    chk("m_req", {31'd0, inst_req}, {31'd0, m_offer});
    if (m_offer) chk("m_addr", inst_addr, m_addr);
    chk("m_valid", {31'd0, if_valid}, {31'd0, m_have});
    chk("m_stall", {31'd0, fetch_stall}, {31'd0, m_stall});
    if (m_have) begin
      chk("m_if_pc", if_pc, m_pc);
      chk("m_if_inst", if_inst, m_inst);
      chk("m_if_adel", {31'd0, if_adel}, {31'd0, m_adel});
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_cmp();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rn, input logic fl, input logic [31:0] tgt,
                       input logic aok, input logic dok, input logic [31:0] rd,
                       input logic alw);
    resetn = rn; flush = fl; flush_tgt = tgt; inst_addr_ok = aok;
    inst_data_ok = dok; inst_rdata = rd; id_allowin = alw;
  endtask

  logic        mem_pend;
  int unsigned mem_wait;
  logic [31:0] mem_data;

  initial begin
    mem_pend = 1'b0; mem_wait = 0; mem_data = '0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    adv();
    sample(); adv();

    // 1: basic fetch, zero-wait memory.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    sample();
    chk("t1_stall_idle", {31'd0, fetch_stall}, 32'd1);
    chk("t1_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("t1_rst_req", {31'd0, inst_req}, 32'd0);
    chk("t1_rst_if_pc", if_pc, 32'h0);
    chk("t1_rst_if_inst", if_inst, 32'h0);
    adv();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    sample();
    chk("t1_req", {31'd0, inst_req}, 32'd1);
    chk("t1_addr", inst_addr, 32'h0);
    adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2402_0001, 1'b1);
    sample(); chk("t1_req_drop", {31'd0, inst_req}, 32'd0); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    sample();
    chk("t1_valid", {31'd0, if_valid}, 32'd1);
    chk("t1_if_pc", if_pc, 32'h0);
    chk("t1_if_inst", if_inst, 32'h2402_0001);
    chk("t1_stall_release", {31'd0, fetch_stall}, 32'd0);
    adv();
    sample();
    chk("t1_valid_off", {31'd0, if_valid}, 32'd0);
    chk("t1_stall_back", {31'd0, fetch_stall}, 32'd1);
    adv();

    // 2: backpressure on pc=4.
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    sample(); chk("t2_addr", inst_addr, 32'h4); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8c43_0010, 1'b0);
    sample(); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("t2_hold_valid", {31'd0, if_valid}, 32'd1);
      chk("t2_hold_pc", if_pc, 32'h4);
      chk("t2_hold_inst", if_inst, 32'h8c43_0010);
      chk("t2_hold_stall", {31'd0, fetch_stall}, 32'd1);
      adv();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    sample(); chk("t2_handoff", {31'd0, fetch_stall}, 32'd0); adv();
    sample(); chk("t2_once", {31'd0, if_valid}, 32'd0); adv();

    // 3: flush in WAIT, pc=8 redirected to 0x100.
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    sample(); chk("t3_addr8", inst_addr, 32'h8); adv();
    drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
    sample(); chk("t3_flush_stall", {31'd0, fetch_stall}, 32'd1); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hdead_beef, 1'b1);
    sample(); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    sample(); chk("t3_dropped", {31'd0, if_valid}, 32'd0); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    sample(); chk("t3_req", {31'd0, inst_req}, 32'd1); chk("t3_addr", inst_addr, 32'h100); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3c01_0000, 1'b1);
    sample(); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    sample(); chk("t3_if_pc", if_pc, 32'h100); adv();

    // 4: flush in REQ with addr_ok delayed two cycles.
    drive(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b1);
    sample(); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    sample(); adv();
    drive(1'b1, 1'b1, 32'hbfc0_0380, 1'b0, 1'b0, 32'h0, 1'b1);
    sample(); chk("t4_addr_a", inst_addr, 32'h8); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    sample(); chk("t4_req_b", {31'd0, inst_req}, 32'd1); chk("t4_addr_b", inst_addr, 32'h8); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    sample(); chk("t4_req_c", {31'd0, inst_req}, 32'd1); chk("t4_addr_c", inst_addr, 32'h8); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_1111, 1'b1);
    sample(); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    sample(); chk("t4_dropped", {31'd0, if_valid}, 32'd0); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    sample(); chk("t4_exc_addr", inst_addr, 32'hbfc0_0380); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4200_0018, 1'b1);
    sample(); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    sample(); chk("t4_if_pc", if_pc, 32'hbfc0_0380); chk("t4_if_inst", if_inst, 32'h4200_0018);
    adv();

    // 5: misaligned pc=6.
    drive(1'b1, 1'b1, 32'h6, 1'b0, 1'b0, 32'h0, 1'b1);
    sample(); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    sample(); chk("t5_no_req", {31'd0, inst_req}, 32'd0); adv();
    sample();
    chk("t5_valid", {31'd0, if_valid}, 32'd1);
    chk("t5_adel", {31'd0, if_adel}, 32'd1);
    chk("t5_inst", if_inst, NOP);
    chk("t5_pc", if_pc, 32'h6);
    chk("t5_no_req_hold", {31'd0, inst_req}, 32'd0);
    adv();

    // 6: flush with data_ok in WAIT, then reset in WAIT.
    drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b1);
    sample(); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    sample(); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    sample(); chk("t6_addr", inst_addr, 32'h200); adv();
    drive(1'b1, 1'b1, 32'h300, 1'b0, 1'b1, 32'h0000_0055, 1'b1);
    sample(); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    sample(); chk("t6_flush_drop", {31'd0, if_valid}, 32'd0); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    sample(); chk("t6_addr300", inst_addr, 32'h300); adv();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    sample(); adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0077, 1'b1);
    sample();
    chk("t6_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("t6_rst_req", {31'd0, inst_req}, 32'd0);
    chk("t6_rst_if_pc", if_pc, 32'h0);
    chk("t6_rst_if_inst", if_inst, 32'h0);
    chk("t6_rst_adel", {31'd0, if_adel}, 32'd0);
    adv();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    sample(); chk("t6_refetch", {31'd0, inst_req}, 32'd1); chk("t6_refetch_addr", inst_addr, 32'h0);
    adv();

    // Randomized traffic: single-outstanding memory with 1..3 cycle read latency,
    // spurious handshakes outside the windows where they matter.
    for (int c = 0; c < 4000; c++) begin
      logic [31:0] tgt;
      resetn     = ($urandom_range(0, 199) != 0);
      flush      = ($urandom_range(0, 9) == 0);
      tgt        = $urandom;
      flush_tgt  = ($urandom_range(0, 7) == 0) ? tgt : {tgt[31:2], 2'b00};
      id_allowin = ($urandom_range(0, 2) != 0);
      inst_data_ok = 1'b0;
      inst_rdata   = $urandom;
      if (mem_pend) begin
        mem_wait--;
        if (mem_wait == 0) begin
          inst_data_ok = 1'b1;
          inst_rdata   = mem_data;
          mem_pend     = 1'b0;
        end
      end else if (!m_fly && $urandom_range(0, 7) == 0) begin
        inst_data_ok = 1'b1;
      end
      inst_addr_ok = !mem_pend && ($urandom_range(0, 1) == 1);
      if (inst_addr_ok && m_offer) begin
        mem_pend = 1'b1;
        mem_wait = $urandom_range(1, 3);
        mem_data = m_addr ^ 32'h5a5a_0f0f;
      end
      sample();
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
